reset_ctrl: RTL and testbench
=============================

RESET_CTRL -- requirements
Module: reset_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flop count of the button synchronizer (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable cycles needed to accept a button change (10 ms at 25 MHz).
REQ-003 SHALL have parameter PHY_HOLD_CYCLES, default 250000, meaning cycles phy_rst_ is held low per sequence.
REQ-004 SHALL have parameter CORE_DELAY_CYCLES, default 25000, meaning cycles between phy_rst_ release and core_rst release.
REQ-005 SHALL have port clk, input, 1, the 25 MHz oscillator clock and sole clock of the block.
REQ-006 SHALL have port rst_, input, 1, asynchronous active-low reset; deassertion synchronous to clk is provided upstream.
REQ-007 SHALL have port button, input, 1, raw active-low pushbutton, asynchronous to clk.
REQ-008 SHALL have port core_rst, output, 1, active-high reset to the SoC core.
REQ-009 SHALL have port phy_rst_, output, 1, active-low Ethernet PHY reset pin.
REQ-010 SHALL have port rst_done, output, 1, high while the sequence is complete and the SoC is running.
REQ-011 SHALL have port btn_resets, output, 8, count of button-initiated reset sequences.

Function
REQ-012 SHALL pass button through SYNC_STAGES flops; all flops reset to 1 (released).
REQ-013 SHALL keep a debounced level deb (reset 1) and a counter: increment while sync output != deb, clear when equal; on the DEBOUNCE_CYCLES-th consecutive differing cycle, deb flips and the counter clears on the same edge.
REQ-014 Latency from a raw button edge held stable to the deb change SHALL be SYNC_STAGES + DEBOUNCE_CYCLES clk edges; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change deb.
REQ-015 SHALL implement states PHY_RST, CORE_WAIT and RUN with one shared cycle counter.
- PHY_RST: phy_rst_=0, core_rst=1, rst_done=0.
- CORE_WAIT: phy_rst_=1, core_rst=1, rst_done=0.
- RUN: phy_rst_=1, core_rst=0, rst_done=1.
REQ-016 In PHY_RST, while deb=0 (pressed), the counter SHALL be held at 0; otherwise it increments, and when it reaches PHY_HOLD_CYCLES-1 the state goes to CORE_WAIT with the counter cleared.
REQ-017 In CORE_WAIT, when the counter reaches CORE_DELAY_CYCLES-1 the state goes to RUN with the counter cleared.
REQ-018 A deb 1->0 transition (press) in any state SHALL force PHY_RST with the counter at 0 on the next edge; the press has priority over any simultaneous counter-terminal transition.
REQ-019 Each press accepted per REQ-018 SHALL increment btn_resets by 1, saturating at 255; power-on reset sequences SHALL not count.
REQ-020 All outputs SHALL be registered and decoded from state only, with no combinational path from button.
REQ-021 A press during PHY_RST SHALL restart the hold, so phy_rst_ is low for at least PHY_HOLD_CYCLES cycles after the last debounced release.

Reset
REQ-022 While rst_=0, outputs SHALL be asynchronously: state PHY_RST, counters 0, deb=1, phy_rst_=0, core_rst=1, rst_done=0, btn_resets=0.
REQ-023 After rst_ rises, the first edge SHALL count as cycle 0 of PHY_RST; rst_ assertion at any point in the sequence SHALL abort it immediately per REQ-022.

Verification
REQ-024 Bench parameters SHALL be SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PHY_HOLD_CYCLES=8 and CORE_DELAY_CYCLES=3, covering the scenarios below.
- Power-on: rst_ low 5 cycles then high, button=1. Required: phy_rst_ rises after edge 8, core_rst falls and rst_done rises after edge 11, btn_resets=0.
- Clean press in RUN: button low 20 cycles, then high. Required: phy_rst_=0 at edge 6 after the fall; it is held until deb release, then 8 further cycles; btn_resets=1.
- Glitch: button low 3 cycles in RUN. Required: no output change, btn_resets=0.
- Press in CORE_WAIT on the counter-terminal cycle. Required: next state PHY_RST, not RUN.
- Saturation: 260 presses. Required: btn_resets=255.
- rst_ pulsed low mid-CORE_WAIT. Required: immediate phy_rst_=0, core_rst=1, btn_resets=0, then the full power-on sequence replays.

Source files
------------

// File: rtl/reset_ctrl.sv
// Board reset controller.
// Synchronises and debounces an active-low pushbutton, then sequences the
// Ethernet PHY reset and the SoC core reset. It also counts button-initiated
// reset sequences, saturating at 255.
module reset_ctrl #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int PHY_HOLD_CYCLES   = 250000,
  parameter int CORE_DELAY_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       button,
  output logic       core_rst,
  output logic       phy_rst_,
  output logic       rst_done,
  output logic [7:0] btn_resets
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SEQ_MAX = (PHY_HOLD_CYCLES > CORE_DELAY_CYCLES) ? PHY_HOLD_CYCLES : CORE_DELAY_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEQ_W-1:0] PHY_LAST  = SEQ_W'(PHY_HOLD_CYCLES - 1);
  localparam logic [SEQ_W-1:0] CORE_LAST = SEQ_W'(CORE_DELAY_CYCLES - 1);

  typedef enum logic [1:0] {
    PHY_RST   = 2'd0,
    CORE_WAIT = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic                   deb_reg, deb_next;
  logic [DEB_W-1:0]       deb_cnt_reg, deb_cnt_next;
  logic                   press;
  state_t                 state_reg, state_next;
  logic [SEQ_W-1:0]       seq_cnt_reg, seq_cnt_next;
  logic [7:0]             btn_cnt_next;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // Button synchroniser chain; idles at 1 (released).
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], button};
    end
  end

  // Debounce: count consecutive cycles where the synchronised level differs from deb.
  // A press is the 1->0 flip of deb, seen here one edge early so that
  // the FSM jumps to PHY_RST on the same edge that deb falls.
  always_comb begin
    deb_next     = deb_reg;
    deb_cnt_next = '0;
    press        = 1'b0;
    if (sync_out != deb_reg) begin
      if (deb_cnt_reg == DEB_LAST) begin
        deb_next = ~deb_reg;
        press    = deb_reg;
      end else begin
        deb_cnt_next = deb_cnt_reg + 1'b1;
      end
    end
  end

  // Reset sequencer next state. A press overrides any terminal-count move.
  always_comb begin
    state_next   = state_reg;
    seq_cnt_next = seq_cnt_reg;
    case (state_reg)
      PHY_RST: begin
        if (!deb_reg) begin
          seq_cnt_next = '0;
        end else if (seq_cnt_reg == PHY_LAST) begin
          state_next   = CORE_WAIT;
          seq_cnt_next = '0;
        end else begin
          seq_cnt_next = seq_cnt_reg + 1'b1;
        end
      end
      CORE_WAIT: begin
        if (seq_cnt_reg == CORE_LAST) begin
          state_next   = RUN;
          seq_cnt_next = '0;
        end else begin
          seq_cnt_next = seq_cnt_reg + 1'b1;
        end
      end
      RUN: begin
        seq_cnt_next = '0;
      end
      default: begin
        state_next   = PHY_RST;
        seq_cnt_next = '0;
      end
    endcase
    if (press) begin
      state_next   = PHY_RST;
      seq_cnt_next = '0;
    end
  end

  // Saturating count of button-initiated sequences.
  always_comb begin
    btn_cnt_next = btn_resets;
    if (press && (btn_resets != 8'hFF)) begin
      btn_cnt_next = btn_resets + 8'd1;
    end
  end

  // State, counters and outputs. Outputs are registered from the next state,
  // so they always match the state register and never see the button directly.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      deb_reg     <= 1'b1;
      deb_cnt_reg <= '0;
      state_reg   <= PHY_RST;
      seq_cnt_reg <= '0;
      btn_resets  <= 8'd0;
      phy_rst_    <= 1'b0;
      core_rst    <= 1'b1;
      rst_done    <= 1'b0;
    end else begin
      deb_reg     <= deb_next;
      deb_cnt_reg <= deb_cnt_next;
      state_reg   <= state_next;
      seq_cnt_reg <= seq_cnt_next;
      btn_resets  <= btn_cnt_next;
      phy_rst_    <= (state_next != PHY_RST);
      core_rst    <= (state_next != RUN);
      rst_done    <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl.
// A reference model tracks the button history and the time elapsed since
// the start of the current reset sequence. Expected outputs are derived from
// that elapsed time.
module tb_reset_ctrl;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int CORE = 3;

  logic       clk = 1'b0;
  logic       rst_;
  logic       button;
  logic       core_rst;
  logic       phy_rst_;
  logic       rst_done;
  logic [7:0] btn_resets;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic m_sync [SYNC];
  logic m_deb;
  int   m_run;       // consecutive cycles the synchronised level differs from m_deb
  int   m_since;     // cycles elapsed in the current sequence (capped at HOLD+CORE)
  int   m_presses;

  always #5 clk = ~clk;

  reset_ctrl #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DEB),
    .PHY_HOLD_CYCLES  (HOLD),
    .CORE_DELAY_CYCLES(CORE)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .button    (button),
    .core_rst  (core_rst),
    .phy_rst_  (phy_rst_),
    .rst_done  (rst_done),
    .btn_resets(btn_resets)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b1;
    m_deb     = 1'b1;
    m_run     = 0;
    m_since   = 0;
    m_presses = 0;
  endtask

  task automatic model_step();
    logic sync_old;
    logic deb_old;
    logic pressed;
    if (!rst_) begin
      model_reset();
      return;
    end
    sync_old = m_sync[SYNC-1];
    deb_old  = m_deb;
    pressed  = 1'b0;
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = button;
    if (sync_old != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb   = ~m_deb;
        m_run   = 0;
        pressed = (m_deb == 1'b0);
      end
    end else begin
      m_run = 0;
    end
    if (pressed) begin
      m_since = 0;
      if (m_presses < 255) m_presses++;
    end else if (m_since < HOLD && deb_old == 1'b0) begin
      m_since = 0;
    end else if (m_since < HOLD + CORE) begin
      m_since++;
    end
  endtask

  task automatic check_model();
    check("phy_rst_",   {7'd0, phy_rst_}, {7'd0, (m_since >= HOLD)});
    check("core_rst",   {7'd0, core_rst}, {7'd0, (m_since < HOLD + CORE)});
    check("rst_done",   {7'd0, rst_done}, {7'd0, (m_since >= HOLD + CORE)});
    check("btn_resets", btn_resets, 8'(m_presses));
  endtask

  // One clock: drive button, let the edge happen, step the model, compare on the falling edge.
  task automatic tick(input logic b);
    button = b;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic pulse(input int lo, input int hi);
    for (int i = 0; i < lo; i++) tick(1'b0);
    for (int i = 0; i < hi; i++) tick(1'b1);
  endtask

  // Assert rst_ away from the clock edge and confirm the asynchronous clear.
  task automatic apply_reset(input int cycles);
    rst_ = 1'b0;
    #1;
    model_reset();
    check("areset_phy",  {7'd0, phy_rst_}, 8'd0);
    check("areset_core", {7'd0, core_rst}, 8'd1);
    check("areset_done", {7'd0, rst_done}, 8'd0);
    check("areset_btn",  btn_resets, 8'd0);
    for (int i = 0; i < cycles; i++) tick(1'b1);
    rst_ = 1'b1;
  endtask

  // Power-on sequence with the button released: fixed edges for phy and core release.
  task automatic power_on_seq();
    for (int e = 1; e <= 12; e++) begin
      tick(1'b1);
      if (e == 7)  check("po_phy_e7",   {7'd0, phy_rst_}, 8'd0);
      if (e == 8)  check("po_phy_e8",   {7'd0, phy_rst_}, 8'd1);
      if (e == 10) check("po_core_e10", {7'd0, core_rst}, 8'd1);
      if (e == 11) check("po_core_e11", {7'd0, core_rst}, 8'd0);
      if (e == 11) check("po_done_e11", {7'd0, rst_done}, 8'd1);
    end
    check("po_btn", btn_resets, 8'd0);
  endtask

  initial begin
    rst_   = 1'b1;
    button = 1'b1;
    model_reset();
    #2;

    $display("scenario: power-on");
    apply_reset(5);
    power_on_seq();

    $display("scenario: glitch of 3 cycles in RUN");
    pulse(3, 12);
    check("glitch_btn",  btn_resets, 8'd0);
    check("glitch_done", {7'd0, rst_done}, 8'd1);

    $display("scenario: clean press in RUN");
    for (int i = 0; i < 5; i++) tick(1'b0);
    check("press_e5_phy", {7'd0, phy_rst_}, 8'd1);
    tick(1'b0);
    check("press_e6_phy", {7'd0, phy_rst_}, 8'd0);
    for (int i = 0; i < 14; i++) tick(1'b0);
    for (int i = 0; i < 13; i++) tick(1'b1);
    check("release_e13_phy", {7'd0, phy_rst_}, 8'd0);
    tick(1'b1);
    check("release_e14_phy", {7'd0, phy_rst_}, 8'd1);
    check("press_btn", btn_resets, 8'd1);
    tick(1'b1);

    $display("scenario: rst_ pulse mid-CORE_WAIT");
    apply_reset(2);
    power_on_seq();

    $display("scenario: press on CORE_WAIT terminal cycle");
    apply_reset(3);
    for (int e = 1; e <= 5; e++) tick(1'b1);
    for (int e = 6; e <= 15; e++) begin
      tick(1'b0);
      if (e == 11) check("term_phy",  {7'd0, phy_rst_}, 8'd0);
      if (e == 11) check("term_done", {7'd0, rst_done}, 8'd0);
    end
    for (int i = 0; i < 16; i++) tick(1'b1);
    check("term_btn", btn_resets, 8'd1);

    $display("scenario: random button activity");
    for (int n = 0; n < 40; n++) begin
      pulse(int'($urandom_range(1, 12)), int'($urandom_range(1, 25)));
    end

    $display("scenario: 260 presses for saturation");
    for (int n = 0; n < 260; n++) pulse(6, 6);
    check("sat_btn", btn_resets, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
